instruction_sequencer: RTL and testbench

Fetch-and-issue front end for the 8-bit CPU datapath. It holds a small writable program memory, steps a program counter and decodes each instruction word into the operand A, operand B and 3-bit ALU-select fields consumed by the ALU/register datapath. Each ALU operation is issued over a valid/ready handshake. The block also executes jump, no-op and halt instructions internally.

---
 rtl/instruction_sequencer.sv | 137 +++++++++++++
 tb/tb_instruction_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_sequencer.sv
// instruction_sequencer
//   Fetch-and-issue front end for the 8-bit CPU datapath. Holds a writable
//   2^ADDR_W x 24 program memory, steps a program counter, and decodes each
//   word into operand A/B and a 3-bit ALU select. ALU words are issued over a
//   valid/ready handshake; JMP, NOP and HALT are executed internally.
//
//   Word layout: [23:22] class (00 ALU, 01 JMP, 10 HALT, 11 NOP),
//                [21:19] alu_sel, [18:16] reserved, [15:8] A, [7:0] B.
//                JMP target is B[ADDR_W-1:0] (so ADDR_W must be <= 8).
//
// Ports
//   clk, rst                : clock, synchronous active-high reset
//   load_en/addr/data       : program-memory write (IDLE/HALTED only)
//   start                   : run from pc=0 (IDLE/HALTED only)
//   a, b, alu_sel           : decoded operation to the datapath
//   issue_valid/issue_ready : operation handshake
//   pc, busy, halted        : status
module instruction_sequencer #(
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [23:0]       load_data,
   input  logic              start,
   output logic [7:0]        a,
   output logic [7:0]        b,
   output logic [2:0]        alu_sel,
   output logic              issue_valid,
   input  logic              issue_ready,
   output logic [ADDR_W-1:0] pc,
   output logic              busy,
   output logic              halted
);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALTED} state_e;

   localparam logic [1:0]        CLS_ALU  = 2'b00;
   localparam logic [1:0]        CLS_JMP  = 2'b01;
   localparam logic [1:0]        CLS_NOP  = 2'b11;
   localparam int                DEPTH    = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] PC_ONE   = 1;

   logic [23:0]       mem_q [DEPTH];
   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [1:0]        cls_q, cls_d;
   logic [2:0]        sel_q, sel_d;
   logic [7:0]        a_q, a_d, b_q, b_d;
   logic [23:0]       rd_word;
   logic              ctl_open;
   logic              unused_rsvd;

   // load/start are only honoured while the sequencer is not running
   assign ctl_open    = (state_q == S_IDLE) || (state_q == S_HALTED);
   assign rd_word     = mem_q[pc_q];
   assign unused_rsvd = ^rd_word[18:16];

   // Program memory is deliberately outside the reset domain so a reset
   // preserves the loaded program.
   always_ff @(posedge clk) begin
      if (load_en && ctl_open) mem_q[load_addr] <= load_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         cls_q   <= '0;
         sel_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cls_q   <= cls_d;
         sel_q   <= sel_d;
         a_q     <= a_d;
         b_q     <= b_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cls_d   = cls_q;
      sel_d   = sel_q;
      a_d     = a_q;
      b_d     = b_q;
      case (state_q)
         S_IDLE, S_HALTED: begin
            if (start) begin
               state_d = S_FETCH;
               pc_d    = '0;
            end
         end
         S_FETCH: begin
            // operand fields load for every class; only ALU words issue them
            cls_d   = rd_word[23:22];
            sel_d   = rd_word[21:19];
            a_d     = rd_word[15:8];
            b_d     = rd_word[7:0];
            state_d = S_EXEC;
         end
         S_EXEC: begin
            case (cls_q)
               CLS_ALU: begin
                  if (issue_ready) begin
                     pc_d    = pc_q + PC_ONE;
                     state_d = S_FETCH;
                  end
               end
               CLS_JMP: begin
                  pc_d    = b_q[ADDR_W-1:0];
                  state_d = S_FETCH;
               end
               CLS_NOP: begin
                  pc_d    = pc_q + PC_ONE;
                  state_d = S_FETCH;
               end
               default: state_d = S_HALTED;  // HALT: pc stays on the HALT word
            endcase
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign a           = a_q;
   assign b           = b_q;
   assign alu_sel     = sel_q;
   assign pc          = pc_q;
   assign issue_valid = (state_q == S_EXEC) && (cls_q == CLS_ALU);
   assign busy        = (state_q == S_FETCH) || (state_q == S_EXEC);
   assign halted      = (state_q == S_HALTED);

endmodule

// File: tb/tb_instruction_sequencer.sv
module tb_instruction_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load_en = 1'b0;
   logic [3:0]  load_addr = '0;
   logic [23:0] load_data = '0;
   logic        start = 1'b0;
   logic        issue_ready = 1'b0;
   logic [7:0]  a, b;
   logic [2:0]  alu_sel;
   logic        issue_valid;
   logic [3:0]  pc;
   logic        busy, halted;

   int nchk = 0;
   int nerr = 0;

   // reference program image, updated whenever the bench writes the DUT
   logic [23:0] mdl_mem [16];

   typedef struct packed {
      logic [3:0] pc;
      logic [2:0] sel;
      logic [7:0] a;
      logic [7:0] b;
   } iss_t;

   instruction_sequencer #(.ADDR_W(4)) dut (
      .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
      .load_data(load_data), .start(start), .a(a), .b(b), .alu_sel(alu_sel),
      .issue_valid(issue_valid), .issue_ready(issue_ready), .pc(pc),
      .busy(busy), .halted(halted)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: got no finish, exp finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h exp %0h", tag, got, exp);
      end
   endtask

   function automatic logic [23:0] mk(input logic [1:0] c, input logic [2:0] s,
                                      input logic [7:0] aa, input logic [7:0] bb);
      return {c, s, 3'b000, aa, bb};
   endfunction

   task automatic ld(input logic [3:0] ad, input logic [23:0] d);
      @(negedge clk);
      load_en = 1'b1; load_addr = ad; load_data = d;
      mdl_mem[ad] = d;
      @(negedge clk);
      load_en = 1'b0;
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_a"}, a, 0);
      chk({tag, "_b"}, b, 0);
      chk({tag, "_sel"}, alu_sel, 0);
      chk({tag, "_pc"}, pc, 0);
      chk({tag, "_v"}, issue_valid, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_halt"}, halted, 0);
   endtask

   task automatic do_rst(input string tag);
      @(negedge clk);
      rst = 1'b1; start = 1'b0; issue_ready = 1'b0;
      @(negedge clk);
      chk_reset_outs(tag);
      rst = 1'b0;
   endtask

   // Runs the program from pc=0 (optionally with a same-cycle write) and
   // checks every handshake, stall stability and the final halt against a
   // program walk of the reference image.
   task automatic run_prog(input bit do_ld, input logic [3:0] la,
                           input logic [23:0] ldw, input int rdy_pct);
      iss_t q[$];
      iss_t cur, held;
      int pcv, hpc;
      logic [23:0] w;
      bit done, stalled, rdy;
      if (do_ld) mdl_mem[la] = ldw;
      pcv = 0; hpc = -1;
      for (int s = 0; s < 64; s++) begin
         w = mdl_mem[pcv];
         if (w[23:22] == 2'b00) begin
            q.push_back({pcv[3:0], w[21:19], w[15:8], w[7:0]});
            pcv = (pcv + 1) % 16;
         end else if (w[23:22] == 2'b01) pcv = int'(w[3:0]);
         else if (w[23:22] == 2'b11) pcv = (pcv + 1) % 16;
         else begin
            hpc = pcv;
            break;
         end
      end
      @(negedge clk);
      start = 1'b1;
      if (do_ld) begin
         load_en = 1'b1; load_addr = la; load_data = ldw;
      end
      @(negedge clk);
      start = 1'b0; load_en = 1'b0;
      done = 0; stalled = 0;
      for (int c = 0; c < 600 && !done; c++) begin
         if (c > 0) @(negedge clk);
         cur = {pc, alu_sel, a, b};
         if (stalled) begin
            chk("stall_v", issue_valid, 1);
            chk("stall_hold", cur, held);
         end
         stalled = 0;
         if (!busy && issue_valid) chk("v_not_busy", issue_valid, 0);
         if (halted) begin
            chk("halt_pc", pc, hpc);
            chk("iss_left", q.size(), 0);
            done = 1;
         end else if (issue_valid) begin
            rdy = ($urandom_range(0, 99) < rdy_pct);
            issue_ready = rdy;
            if (rdy) begin
               if (q.size() == 0) chk("iss_extra", 1, 0);
               else chk("iss", cur, q.pop_front());
            end else begin
               stalled = 1; held = cur;
            end
         end else begin
            issue_ready = ($urandom_range(0, 99) < rdy_pct);
         end
      end
      if (!done) chk("halt_timeout", 0, 1);
      issue_ready = 1'b0;
   endtask

   initial begin
      logic [23:0] w;
      int tgt;
      // ---------------- reset state
      repeat (2) @(negedge clk);
      chk_reset_outs("rst0");
      rst = 1'b0;
      for (int i = 0; i < 16; i++) ld(i[3:0], mk(2'b10, 3'd0, 8'h00, 8'h00));

      // ---------------- basic ALU then HALT, exact timing
      ld(4'd0, mk(2'b00, 3'd3, 8'h12, 8'h34));
      ld(4'd1, mk(2'b10, 3'd0, 8'h00, 8'h00));
      @(negedge clk); start = 1'b1; issue_ready = 1'b1;
      @(negedge clk); start = 1'b0;
      chk("t1_fetch_v", issue_valid, 0);
      chk("t1_busy", busy, 1);
      @(negedge clk);
      chk("t1_v", issue_valid, 1);
      chk("t1_a", a, 8'h12);
      chk("t1_b", b, 8'h34);
      chk("t1_sel", alu_sel, 3);
      @(negedge clk);
      chk("t1_fetch2_v", issue_valid, 0);
      chk("t1_pc1", pc, 1);
      @(negedge clk);
      chk("t1_halt_early", halted, 0);
      @(negedge clk);
      chk("t1_halted", halted, 1);
      chk("t1_halt_pc", pc, 1);
      chk("t1_busy_end", busy, 0);
      issue_ready = 1'b0;

      // ---------------- backpressure
      ld(4'd0, mk(2'b00, 3'd6, 8'hA5, 8'h5A));
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      chk("bp_v", issue_valid, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_hold", {issue_valid, a, b, alu_sel, pc}, {1'b1, 8'hA5, 8'h5A, 3'd6, 4'd0});
      end
      issue_ready = 1'b1;
      @(negedge clk);
      issue_ready = 1'b0;
      chk("bp_v_drop", issue_valid, 0);
      chk("bp_pc", pc, 1);
      @(negedge clk);
      chk("bp_no_reissue", issue_valid, 0);
      @(negedge clk);
      chk("bp_halted", halted, 1);
      chk("bp_halt_pc", pc, 1);

      // ---------------- JMP and pc wrap
      ld(4'd15, mk(2'b11, 3'd0, 8'h00, 8'h00));
      ld(4'd0, mk(2'b01, 3'd2, 8'h77, 8'hEF));  // upper target bits ignored
      @(negedge clk); start = 1'b1; issue_ready = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int c = 0; c < 16; c++) begin
         chk("jmp_pc", pc, ((c / 2) % 2) ? 15 : 0);
         chk("jmp_no_v", issue_valid, 0);
         @(negedge clk);
      end
      do_rst("rst_jmp");

      // ---------------- load/start ignored while busy
      ld(4'd0, mk(2'b00, 3'd1, 8'h11, 8'h22));
      ld(4'd1, mk(2'b00, 3'd2, 8'h33, 8'h44));
      ld(4'd2, mk(2'b10, 3'd0, 8'h00, 8'h00));
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      chk("ign_v", issue_valid, 1);
      load_en = 1'b1; load_addr = 4'd1; load_data = mk(2'b00, 3'd7, 8'hDE, 8'hAD);
      start = 1'b1;
      @(negedge clk);
      load_en = 1'b0; start = 1'b0;
      chk("ign_pc", pc, 0);
      chk("ign_still_v", issue_valid, 1);
      issue_ready = 1'b1;
      @(negedge clk);
      chk("ign_pc1", pc, 1);
      @(negedge clk);
      chk("ign_iss2", {issue_valid, a, b, alu_sel}, {1'b1, 8'h33, 8'h44, 3'd2});
      for (int c = 0; c < 10 && !halted; c++) @(negedge clk);
      chk("ign_halted", halted, 1);
      chk("ign_halt_pc", pc, 2);
      issue_ready = 1'b0;
      run_prog(0, 4'd0, 24'd0, 60);  // replays image with [1] untouched

      // ---------------- reset while an issue is pending
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      chk("rmi_v", issue_valid, 1);
      rst = 1'b1;
      @(negedge clk);
      chk_reset_outs("rmi");
      rst = 1'b0;
      run_prog(0, 4'd0, 24'd0, 50);

      // ---------------- same-cycle load and start from HALTED
      chk("sc_pre_halted", halted, 1);
      run_prog(1, 4'd0, mk(2'b00, 3'd5, 8'hFF, 8'h01), 100);

      // ---------------- random programs
      for (int p = 0; p < 8; p++) begin
         for (int i = 0; i < 16; i++) begin
            if (i == 15) w = mk(2'b10, 3'($urandom), 8'($urandom), 8'($urandom));
            else begin
               tgt = $urandom_range(0, 9);
               if (tgt < 6) w = mk(2'b00, 3'($urandom), 8'($urandom), 8'($urandom));
               else if (tgt < 8) w = mk(2'b11, 3'($urandom), 8'($urandom), 8'($urandom));
               else if (tgt < 9) begin
                  tgt = $urandom_range(i + 1, 15);
                  w = mk(2'b01, 3'($urandom), 8'($urandom), {4'($urandom), 4'(tgt)});
               end else w = mk(2'b10, 3'($urandom), 8'($urandom), 8'($urandom));
            end
            w[18:16] = 3'($urandom);
            ld(i[3:0], w);
         end
         run_prog(0, 4'd0, 24'd0, $urandom_range(20, 100));
      end

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
